// File: rtl/ll8_to_fifo36.sv
// ll8_to_fifo36 -- packs an 8-bit active-low LocalLink byte stream into
// 36-bit FIFO words for the RX FIFO. The word format matches the
// 36-to-LL8 TX serializer:
//   [35:34] occ (01/10/11 = 1/2/3 valid bytes, 00 = 4), [33] eof, [32] sof,
//   [31:0] bytes, first byte in [31:24].
// Accepts one byte per clock, with no bubble at word boundaries.
//
// Ports:
//   clk, reset (async, active high), clear (sync flush, also clears error)
//   ll_data, ll_sof_n, ll_eof_n, ll_src_rdy_n, ll_dst_rdy_n : LocalLink in
//   f36_data, f36_src_rdy_o, f36_dst_rdy_i                  : FIFO out
//   error : sticky framing error (tied 0 unless LL8_TO_FIFO36_ERRCHK_EN)
//   debug : current state encoding
//
// Build option: define LL8_TO_FIFO36_ERRCHK_EN to enable in-frame tracking.
// A SOF seen mid-frame closes the current word as a frame end. A byte seen
// outside a frame is discarded. Both cases raise error.
//
// state | meaning
// ------+--------------------------------------------
// XB0   | next byte goes to lane 0 (starts a new word)
// XB1   | next byte goes to lane 1
// XB2   | next byte goes to lane 2
// XB3   | next byte goes to lane 3
// WORD  | complete word held, f36_src_rdy_o asserted
`timescale 1ns/1ps

module ll8_to_fifo36 (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic [7:0]  ll_data,
  input  logic        ll_sof_n,
  input  logic        ll_eof_n,
  input  logic        ll_src_rdy_n,
  output logic        ll_dst_rdy_n,
  output logic [35:0] f36_data,
  output logic        f36_src_rdy_o,
  input  logic        f36_dst_rdy_i,
  output logic        error,
  output logic [2:0]  debug
);

  typedef enum logic [2:0] {
    XB0  = 3'd0,
    XB1  = 3'd1,
    XB2  = 3'd2,
    XB3  = 3'd3,
    WORD = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic [35:0] word_nxt;
  logic        ll_sof, ll_eof, ll_src_rdy, ll_dst_rdy;
  logic        take, drain;
  logic [1:0]  lane;
  logic        ld_en, ld_sof, ld_eof;
  logic [7:0]  ld_data;

`ifdef LL8_TO_FIFO36_ERRCHK_EN
  logic       error_q, error_nxt;
  logic       in_frame, in_frame_nxt;
  // Byte that started a new frame while the previous one was being closed.
  // It waits here until the closing word drains.
  logic       pend_valid, pend_valid_nxt;
  logic       pend_eof, pend_eof_nxt;
  logic [7:0] pend_data, pend_data_nxt;
`endif

  assign ll_sof     = ~ll_sof_n;
  assign ll_eof     = ~ll_eof_n;
  assign ll_src_rdy = ~ll_src_rdy_n;
  assign take       = ll_src_rdy & ll_dst_rdy;
  assign drain      = f36_src_rdy_o & f36_dst_rdy_i;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= XB0;
      f36_data <= '0;
`ifdef LL8_TO_FIFO36_ERRCHK_EN
      error_q    <= 1'b0;
      in_frame   <= 1'b0;
      pend_valid <= 1'b0;
      pend_eof   <= 1'b0;
      pend_data  <= '0;
`endif
    end else if (clear) begin
      state    <= XB0;
      f36_data <= '0;
`ifdef LL8_TO_FIFO36_ERRCHK_EN
      error_q    <= 1'b0;
      in_frame   <= 1'b0;
      pend_valid <= 1'b0;
      pend_eof   <= 1'b0;
      pend_data  <= '0;
`endif
    end else begin
      state    <= state_nxt;
      f36_data <= word_nxt;
`ifdef LL8_TO_FIFO36_ERRCHK_EN
      error_q    <= error_nxt;
      in_frame   <= in_frame_nxt;
      pend_valid <= pend_valid_nxt;
      pend_eof   <= pend_eof_nxt;
      pend_data  <= pend_data_nxt;
`endif
    end
  end

  // Next-state and next-word logic
  always_comb begin
    state_nxt = state;
    word_nxt  = f36_data;
    // A take in WORD only happens alongside a drain, so it fills lane 0.
    lane      = (state == WORD) ? 2'd0 : state[1:0];
    ld_en     = take;
    ld_data   = ll_data;
    ld_sof    = ll_sof;
    ld_eof    = ll_eof;
`ifdef LL8_TO_FIFO36_ERRCHK_EN
    error_nxt      = error_q;
    in_frame_nxt   = in_frame;
    pend_valid_nxt = pend_valid;
    pend_eof_nxt   = pend_eof;
    pend_data_nxt  = pend_data;
`endif

    if (drain) state_nxt = XB0;

`ifdef LL8_TO_FIFO36_ERRCHK_EN
    if (drain && pend_valid) begin
      ld_en          = 1'b1;
      ld_data        = pend_data;
      ld_sof         = 1'b1;
      ld_eof         = pend_eof;
      pend_valid_nxt = 1'b0;
    end else if (take && !ll_sof && !in_frame) begin
      ld_en     = 1'b0;
      error_nxt = 1'b1;
    end else if (take && ll_sof && in_frame) begin
      // Close the open word as a frame end. occ is the byte count so far,
      // so an empty lane-0 word closes with occ=00 and zero data.
      ld_en          = 1'b0;
      error_nxt      = 1'b1;
      pend_valid_nxt = 1'b1;
      pend_data_nxt  = ll_data;
      pend_eof_nxt   = ll_eof;
      in_frame_nxt   = ~ll_eof;
      if (lane == 2'd0) word_nxt[32:0] = '0;
      word_nxt[35:34] = lane;
      word_nxt[33]    = 1'b1;
      state_nxt       = WORD;
    end else if (take) begin
      if (ll_sof) in_frame_nxt = 1'b1;
      if (ll_eof) in_frame_nxt = 1'b0;
    end
`endif

    if (ld_en) begin
      case (lane)
        2'd0: word_nxt = {2'b00, 1'b0, ld_sof, ld_data, 24'h0};
        2'd1: word_nxt[23:16] = ld_data;
        2'd2: word_nxt[15:8]  = ld_data;
        2'd3: word_nxt[7:0]   = ld_data;
        default: word_nxt = f36_data;
      endcase
      if (ld_eof) begin
        state_nxt       = WORD;
        word_nxt[33]    = 1'b1;
        word_nxt[35:34] = lane + 2'd1;  // 4 bytes wraps to 00
      end else if (lane == 2'd3) begin
        state_nxt = WORD;
      end else begin
        state_nxt = state_t'({1'b0, lane + 2'd1});
      end
    end
  end

  // Outputs
  always_comb begin
    f36_src_rdy_o = (state == WORD);
    ll_dst_rdy    = (state != WORD) | f36_dst_rdy_i;
`ifdef LL8_TO_FIFO36_ERRCHK_EN
    if (pend_valid) ll_dst_rdy = 1'b0;
    error = error_q;
`else
    error = 1'b0;
`endif
    ll_dst_rdy_n = ~ll_dst_rdy;
    debug        = state;
  end

endmodule

// File: doc/ll8_to_fifo36.md
Name: ll8_to_fifo36

Overview:
- Packs an 8-bit active-low LocalLink byte stream (e.g. GEMAC RX) into 36-bit FIFO words carrying occupancy and SOF/EOF flags.
- Sits directly upstream of the 36-bit RX FIFO.
- Mirror-image companion of the 36-bit-to-LocalLink-8 TX serializer; uses the identical 36-bit word format.
- Full throughput: one byte per clock, with no bubble at word boundaries.

Parameters:
- None.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- clear  in  1  synchronous flush; discards any partial word
- ll_data  in  8  LocalLink byte
- ll_sof_n  in  1  start of frame, active low
- ll_eof_n  in  1  end of frame, active low
- ll_src_rdy_n  in  1  upstream byte valid, active low
- ll_dst_rdy_n  out  1  this block can accept a byte, active low
- f36_data  out  36  [35:34] occ, [33] eof, [32] sof, [31:0] bytes; first byte in [31:24]
- f36_src_rdy_o  out  1  f36_data valid
- f36_dst_rdy_i  in  1  downstream accepts word
- error  out  1  sticky framing error (see Optional Feature)
- debug  out  3  current state encoding

Behaviour:
- Internal active-high versions: ll_sof = ~ll_sof_n, ll_eof = ~ll_eof_n, ll_src_rdy = ~ll_src_rdy_n.
- Byte accepted ("take") when ll_src_rdy & ll_dst_rdy.
- States (3-bit, as on debug):
  - XB0=0, XB1=1, XB2=2, XB3=3: next byte lane to fill.
  - WORD=4: complete word held, f36_src_rdy_o=1.
- Transfers:
  - Word drains ("drain") when f36_src_rdy_o & f36_dst_rdy_i.
  - ll_dst_rdy = (state!=WORD) | f36_dst_rdy_i.
- Byte placement:
  - A take in XBn writes ll_data into lane n: XB0->[31:24], XB1->[23:16], XB2->[15:8], XB3->[7:0].
  - A take in XB0 also zeroes lanes 1-3 and latches sof = ll_sof. Bit 32 is the SOF of lane 0 only.
- Next state after a take in XBn:
  - ll_eof=1 -> WORD. Set eof=1 and occ: XB0->01, XB1->10, XB2->11, XB3->00. Unwritten lanes read 0.
  - ll_eof=0 and n<3 -> XB(n+1).
  - ll_eof=0 and n=3 -> WORD, eof=0, occ=00.
- In WORD:
  - drain with no take -> XB0.
  - drain with a simultaneous take -> the new byte loads lane 0 of a fresh word (lanes 1-3 cleared, sof/eof/occ re-evaluated per XB0 rules). Next state is XB1, or WORD if that byte has ll_eof.
  - The old word is the one transferred on the drain cycle. The new word's contents appear only from the following cycle.
- Outputs are registered. Latency is 1 clock from the final take of a word to f36_src_rdy_o.
- f36_data is stable while f36_src_rdy_o=1 and f36_dst_rdy_i=0.
- Simultaneous ll_sof and ll_eof on one byte: single-byte frame, word = sof=1, eof=1, occ=01.
- Reset values:
  - state=XB0, f36_data=0, f36_src_rdy_o=0, ll_dst_rdy_n=0 (ready), error=0.
  - In-frame flag=0.
- Reset is asynchronous and may assert mid-word or mid-frame. The partial word is lost and no word is emitted.
- clear has the same effect synchronously, including clearing error. clear has priority over take and drain in the same cycle.

Optional Feature:
- Macro: LL8_TO_FIFO36_ERRCHK_EN.
- Enabled: an in-frame flag is set on a take with ll_sof and cleared on a take with ll_eof.
  - Byte with ll_sof while in-frame: the current word is closed as a frame end. eof=1, occ per current lane count, or occ=00 if in XB0 with no data. The new byte then starts a fresh word. error is set.
  - Byte without ll_sof while not in-frame: byte is taken (ll_dst_rdy honoured) and discarded. error is set.
  - error stays high until clear or reset.
- Disabled: no in-frame tracking. All bytes are packed verbatim. error is tied 0.

Test Plan:
- 8-byte frame 0x01..0x08 (sof on 0x01, eof on 0x08), sink always ready -> words 0x1_01020304 (occ=00, eof=0, sof=1) then 0x2_05060708 (occ=00, eof=1, sof=0). ll_dst_rdy_n stays 0 throughout.
- 6-byte frame 0xA0..0xA5 -> second word = {occ=10, eof=1, sof=0, 0xA4A50000}.
- Frames of 1, 2, 3 bytes back-to-back -> occ 01/10/11, each with sof=1 and eof=1. No idle cycles on the LocalLink side.
- Sink holds f36_dst_rdy_i=0 for 5 cycles while in WORD -> ll_dst_rdy_n=1 and f36_data stable. Release -> drain and a concurrent byte take in the same cycle, no byte lost.
- Reset pulsed mid-frame after 2 bytes -> f36_src_rdy_o=0 immediately (asynchronous). The next frame packs cleanly from lane 0.
- ERRCHK_EN: byte without sof after reset -> error=1, no word emitted. clear -> error=0.
